ex_hazard_controller: RTL and testbench
=======================================

// Module: ex_hazard_controller
// PURPOSE
//  Sequencing controller for the EX stage of the 5-stage MIPS pipeline. Detects load-use hazards,
//  resolves register forwarding into the EX operand muxes, flushes wrong-path instructions on taken
//  branch/jump, and holds the pipeline while a multi-cycle ALU op (mult/div) occupies EX.
//  Drives PC/IF-ID/ID-EX enables, flushes, the PC source select and two stall/flush statistics counters.
// PARAMETERS
//  MULTI_CYCLES  4   EX occupancy in cycles of a multi-cycle op; legal range 2..16
//  COUNT_WIDTH   16  width of StallCount / FlushCount
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high
//  ID_Rs, ID_Rt   in   5   source registers of the instruction in ID
//  ID_UsesRs/Rt   in   1   ID instruction really reads Rs / Rt
//  EX_Rs, EX_Rt   in   5   source registers of the instruction in EX
//  EX_MemRead     in   1   EX instruction is a load
//  EX_RegWrite    in   1   EX instruction writes EX_WriteReg
//  EX_WriteReg    in   5   destination of the EX instruction
//  EX_BranchTaken in   1   branch in EX resolved taken (Branch & Zero condition)
//  EX_Jump        in   1   jump in EX
//  EX_MultiCycle  in   1   EX instruction is a multi-cycle ALU op
//  MEM_RegWrite   in   1   / MEM_WriteReg in 5: writer in MEM stage
//  WB_RegWrite    in   1   / WB_WriteReg  in 5: writer in WB stage
//  PCWrite        out  1   PC load enable
//  IFID_Write     out  1   IF/ID load enable
//  IDEX_Write     out  1   ID/EX load enable
//  IFID_Flush     out  1   IF/ID loads a NOP
//  IDEX_Flush     out  1   ID/EX loads a NOP (bubble)
//  EXMEM_Bubble   out  1   EX/MEM loads a NOP
//  PCSrc          out  2   00 PC+4, 01 BranchAddress, 10 JumpAddress
//  ForwardA/B     out  2   EX operand select: 00 RF, 01 WB value, 10 MEM value
//  MultiDone      out  1   final EX cycle of a multi-cycle op
//  StallCount     out  COUNT_WIDTH  cycles spent stalled, saturating
//  FlushCount     out  COUNT_WIDTH  redirects taken, saturating
// BEHAVIOUR
//  - Registered: state {RUN, MULTI}, down-counter cnt[3:0], StallCount, FlushCount. All else Mealy comb.
//  - Reset (async): state=RUN, cnt=0, counters=0. Idle outputs: PCWrite=IFID_Write=IDEX_Write=1, rest 0.
//  - LoadUse = EX_MemRead & EX_RegWrite & EX_WriteReg!=0 &
//    ((ID_UsesRs & ID_Rs==EX_WriteReg) | (ID_UsesRt & ID_Rt==EX_WriteReg)).
//  - Redirect = EX_BranchTaken | EX_Jump; PCSrc=10 if EX_Jump else 01 if EX_BranchTaken else 00.
//  - Priority per cycle: MultiStall > Redirect > LoadUse > normal.
//  - RUN, EX_MultiCycle=1: MultiStall: PCWrite=IFID_Write=IDEX_Write=0, EXMEM_Bubble=1;
//    next MULTI, cnt=MULTI_CYCLES-2.
//  - MULTI, cnt!=0: MultiStall, cnt--. MULTI, cnt==0: no stall, MultiDone=1, next RUN.
//    EX occupancy = MULTI_CYCLES; stall = MULTI_CYCLES-1 cycles; EX/MEM receives result exactly once.
//  - Redirect (RUN only): IFID_Flush=IDEX_Flush=1, enables stay 1, PCSrc as above; LoadUse ignored.
//  - LoadUse (no Redirect): PCWrite=IFID_Write=0, IDEX_Flush=1; exactly 1 bubble, then MEM forwarding.
//  - Forwarding (comb, every cycle incl. stalls): ForwardA=10 if MEM_RegWrite & MEM_WriteReg!=0 &
//    MEM_WriteReg==EX_Rs; else 01 if same test on WB; else 00. ForwardB identical on EX_Rt. MEM beats WB.
//  - Register $0 never forwarded nor hazard-checked.
//  - StallCount +1 each cycle PCWrite=0; FlushCount +1 each Redirect cycle; both hold at all-ones.
//  - Reset asserted mid-MULTI: immediate return to RUN, cnt=0; no MultiDone pulse.
//  - Redirect/LoadUse inputs while state=MULTI are ignored (instruction in EX is the multi op).
// TESTING
//  - Reset mid-MULTI (cnt=2) -> state RUN, StallCount=0, PCWrite=1 same cycle, no MultiDone.
//  - lw $8 in EX, ID add $9,$8,$1 (UsesRs) -> 1 cycle PCWrite=0,IDEX_Flush=1; next cycle ForwardA=10.
//  - MEM and WB both write $5, EX_Rs=5 -> ForwardA=10; EX_Rs=0 with writers to $0 -> ForwardA=00.
//  - EX_BranchTaken=1 with LoadUse=1 -> PCSrc=01, IFID_Flush=IDEX_Flush=1, PCWrite=1, FlushCount+1.
//  - MULTI_CYCLES=4, EX_MultiCycle at t0 -> stall t0..t2, MultiDone at t3, StallCount=3.
//  - Force 2^COUNT_WIDTH+3 stall cycles -> StallCount saturates at all-ones, no wrap.

Source files
------------

// File: rtl/ex_hazard_controller_if.sv
// Interface bundling the EX-stage hazard inputs and the pipeline control outputs.
// The master side is the datapath, which reports the instruction state. The slave
// side is the hazard controller, which returns enables, flushes and operand selects.
interface ex_hazard_controller_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [4:0]             ID_Rs;
    logic [4:0]             ID_Rt;
    logic                   ID_UsesRs;
    logic                   ID_UsesRt;
    logic [4:0]             EX_Rs;
    logic [4:0]             EX_Rt;
    logic                   EX_MemRead;
    logic                   EX_RegWrite;
    logic [4:0]             EX_WriteReg;
    logic                   EX_BranchTaken;
    logic                   EX_Jump;
    logic                   EX_MultiCycle;
    logic                   MEM_RegWrite;
    logic [4:0]             MEM_WriteReg;
    logic                   WB_RegWrite;
    logic [4:0]             WB_WriteReg;

    logic                   PCWrite;
    logic                   IFID_Write;
    logic                   IDEX_Write;
    logic                   IFID_Flush;
    logic                   IDEX_Flush;
    logic                   EXMEM_Bubble;
    logic [1:0]             PCSrc;
    logic [1:0]             ForwardA;
    logic [1:0]             ForwardB;
    logic                   MultiDone;
    logic [COUNT_WIDTH-1:0] StallCount;
    logic [COUNT_WIDTH-1:0] FlushCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_Rs, EX_Rt, EX_MemRead,
               EX_RegWrite, EX_WriteReg, EX_BranchTaken, EX_Jump, EX_MultiCycle,
               MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg,
        input  PCWrite, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush,
               EXMEM_Bubble, PCSrc, ForwardA, ForwardB, MultiDone,
               StallCount, FlushCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_Rs, EX_Rt, EX_MemRead,
               EX_RegWrite, EX_WriteReg, EX_BranchTaken, EX_Jump, EX_MultiCycle,
               MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg,
        output PCWrite, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush,
               EXMEM_Bubble, PCSrc, ForwardA, ForwardB, MultiDone,
               StallCount, FlushCount
    );
endinterface

// File: rtl/ex_hazard_controller.sv
// EX-stage sequencing controller for the 5-stage MIPS pipeline.
// Priority within one cycle: multi-cycle hold, then redirect, then load-use, then normal flow.
// Forwarding selects are evaluated every cycle, independent of stalls.
module ex_hazard_controller #(
    parameter int MULTI_CYCLES = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    ex_hazard_controller_if.slave  hz
);

    typedef enum logic {RUN, MULTI} state_t;

    state_t                 state, stateNext;
    logic [3:0]             cnt, cntNext;
    logic [COUNT_WIDTH-1:0] stallCount, flushCount;

    logic                   loadUse;
    logic                   redirect;
    logic                   pcWrite, ifidWrite, idexWrite;
    logic                   ifidFlush, idexFlush, exmemBubble, multiDone;
    logic [1:0]             pcSrc;
    logic [1:0]             forwardA, forwardB;

    // Register $0 is hardwired zero, so it never creates a hazard.
    always_comb begin
        loadUse = hz.EX_MemRead && hz.EX_RegWrite && (hz.EX_WriteReg != 5'd0) &&
                  ((hz.ID_UsesRs && (hz.ID_Rs == hz.EX_WriteReg)) ||
                   (hz.ID_UsesRt && (hz.ID_Rt == hz.EX_WriteReg)));
        redirect = hz.EX_BranchTaken || hz.EX_Jump;
    end

    // State register and multi-cycle down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next state and pipeline controls; while in MULTI the redirect/load-use inputs belong to a younger instruction and are ignored.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idexWrite   = 1'b1;
        ifidFlush   = 1'b0;
        idexFlush   = 1'b0;
        exmemBubble = 1'b0;
        multiDone   = 1'b0;
        pcSrc       = 2'b00;
        case (state)
            RUN: begin
                if (hz.EX_MultiCycle) begin
                    pcWrite     = 1'b0;
                    ifidWrite   = 1'b0;
                    idexWrite   = 1'b0;
                    exmemBubble = 1'b1;
                    stateNext   = MULTI;
                    cntNext     = 4'(MULTI_CYCLES - 2);
                end else if (redirect) begin
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                    pcSrc     = hz.EX_Jump ? 2'b10 : 2'b01;
                end else if (loadUse) begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    idexFlush = 1'b1;
                end
            end
            MULTI: begin
                if (cnt != 4'd0) begin
                    pcWrite     = 1'b0;
                    ifidWrite   = 1'b0;
                    idexWrite   = 1'b0;
                    exmemBubble = 1'b1;
                    cntNext     = cnt - 4'd1;
                end else begin
                    multiDone = 1'b1;
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
                cntNext   = 4'd0;
            end
        endcase
    end

    // Operand forwarding: the younger MEM result wins over WB.
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (hz.MEM_RegWrite && (hz.MEM_WriteReg != 5'd0) && (hz.MEM_WriteReg == hz.EX_Rs))
            forwardA = 2'b10;
        else if (hz.WB_RegWrite && (hz.WB_WriteReg != 5'd0) && (hz.WB_WriteReg == hz.EX_Rs))
            forwardA = 2'b01;
        if (hz.MEM_RegWrite && (hz.MEM_WriteReg != 5'd0) && (hz.MEM_WriteReg == hz.EX_Rt))
            forwardB = 2'b10;
        else if (hz.WB_RegWrite && (hz.WB_WriteReg != 5'd0) && (hz.WB_WriteReg == hz.EX_Rt))
            forwardB = 2'b01;
    end

    // Saturating statistics: stalled cycles and redirects actually taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (!pcWrite && (stallCount != '1))
                stallCount <= stallCount + COUNT_WIDTH'(1);
            if (ifidFlush && (flushCount != '1))
                flushCount <= flushCount + COUNT_WIDTH'(1);
        end
    end

    assign hz.PCWrite      = pcWrite;
    assign hz.IFID_Write   = ifidWrite;
    assign hz.IDEX_Write   = idexWrite;
    assign hz.IFID_Flush   = ifidFlush;
    assign hz.IDEX_Flush   = idexFlush;
    assign hz.EXMEM_Bubble = exmemBubble;
    assign hz.PCSrc        = pcSrc;
    assign hz.ForwardA     = forwardA;
    assign hz.ForwardB     = forwardB;
    assign hz.MultiDone    = multiDone;
    assign hz.StallCount   = stallCount;
    assign hz.FlushCount   = flushCount;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Testbench for ex_hazard_controller: directed scenarios followed by randomized
// traffic checked against an occupancy-based behavioural model.
module tb_ex_hazard_controller;

    localparam int MC = 4;
    localparam int CW = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ex_hazard_controller_if #(.COUNT_WIDTH(CW)) hzIf();

    ex_hazard_controller #(.MULTI_CYCLES(MC), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hzIf)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic setIdle();
        hzIf.ID_Rs = 5'd0;          hzIf.ID_Rt = 5'd0;
        hzIf.ID_UsesRs = 1'b0;      hzIf.ID_UsesRt = 1'b0;
        hzIf.EX_Rs = 5'd0;          hzIf.EX_Rt = 5'd0;
        hzIf.EX_MemRead = 1'b0;     hzIf.EX_RegWrite = 1'b0;
        hzIf.EX_WriteReg = 5'd0;    hzIf.EX_BranchTaken = 1'b0;
        hzIf.EX_Jump = 1'b0;        hzIf.EX_MultiCycle = 1'b0;
        hzIf.MEM_RegWrite = 1'b0;   hzIf.MEM_WriteReg = 5'd0;
        hzIf.WB_RegWrite = 1'b0;    hzIf.WB_WriteReg = 5'd0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        setIdle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sets up "lw $8" in EX and an ID instruction reading $8 through Rs.
    task automatic driveLoadUse();
        hzIf.EX_MemRead = 1'b1;  hzIf.EX_RegWrite = 1'b1;  hzIf.EX_WriteReg = 5'd8;
        hzIf.ID_Rs = 5'd8;       hzIf.ID_UsesRs = 1'b1;
        hzIf.ID_Rt = 5'd1;       hzIf.ID_UsesRt = 1'b1;
    endtask

    // Expected operand select from the forwarding rule: newest valid non-$0 writer wins.
    function automatic logic [1:0] fwdRef(input logic [4:0] src,
                                          input logic memW, input logic [4:0] memR,
                                          input logic wbW,  input logic [4:0] wbR);
        if (src == 5'd0) return 2'b00;
        if (memW && memR == src) return 2'b10;
        if (wbW && wbR == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        setIdle();
        reset = 1'b1;
        #1;
        checks++;
        if ({hzIf.PCWrite, hzIf.IFID_Write, hzIf.IDEX_Write} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_enables: got %b expected 111", {hzIf.PCWrite, hzIf.IFID_Write, hzIf.IDEX_Write});
        end
        checks++;
        if ({hzIf.IFID_Flush, hzIf.IDEX_Flush, hzIf.EXMEM_Bubble, hzIf.MultiDone, hzIf.PCSrc, hzIf.ForwardA, hzIf.ForwardB} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_others: got %b expected 0", {hzIf.IFID_Flush, hzIf.IDEX_Flush, hzIf.EXMEM_Bubble, hzIf.MultiDone, hzIf.PCSrc, hzIf.ForwardA, hzIf.ForwardB});
        end
        checks++;
        if (hzIf.StallCount !== '0 || hzIf.FlushCount !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", hzIf.StallCount, hzIf.FlushCount);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        resetDut();
        driveLoadUse();
        #1;
        checks++;
        if ({hzIf.PCWrite, hzIf.IFID_Write, hzIf.IDEX_Write, hzIf.IDEX_Flush, hzIf.IFID_Flush} !== 5'b00110) begin
            errors++;
            $display("[TB] FAIL loaduse_stall: got %b expected 00110", {hzIf.PCWrite, hzIf.IFID_Write, hzIf.IDEX_Write, hzIf.IDEX_Flush, hzIf.IFID_Flush});
        end
        // The load has advanced to MEM and the dependent add is now in EX.
        @(negedge clk);
        setIdle();
        hzIf.MEM_RegWrite = 1'b1;  hzIf.MEM_WriteReg = 5'd8;
        hzIf.EX_Rs = 5'd8;         hzIf.EX_Rt = 5'd1;
        #1;
        checks++;
        if (hzIf.ForwardA !== 2'b10 || hzIf.PCWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loaduse_forward: got fwdA=%b pcw=%b expected fwdA=10 pcw=1", hzIf.ForwardA, hzIf.PCWrite);
        end
        checks++;
        if (hzIf.StallCount !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL loaduse_stallcount: got %0d expected 1", hzIf.StallCount);
        end
        // Same load, but the ID instruction does not actually read Rs.
        @(negedge clk);
        setIdle();
        driveLoadUse();
        hzIf.ID_UsesRs = 1'b0;
        #1;
        checks++;
        if (hzIf.PCWrite !== 1'b1 || hzIf.IDEX_Flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loaduse_unused_src: got pcw=%b flush=%b expected 1/0", hzIf.PCWrite, hzIf.IDEX_Flush);
        end
        // Load into $0 is never a hazard.
        hzIf.ID_UsesRs = 1'b1;  hzIf.EX_WriteReg = 5'd0;  hzIf.ID_Rs = 5'd0;
        #1;
        checks++;
        if (hzIf.PCWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loaduse_reg0: got pcw=%b expected 1", hzIf.PCWrite);
        end
    endtask

    task automatic test_forwarding();
        resetDut();
        hzIf.MEM_RegWrite = 1'b1;  hzIf.MEM_WriteReg = 5'd5;
        hzIf.WB_RegWrite = 1'b1;   hzIf.WB_WriteReg = 5'd5;
        hzIf.EX_Rs = 5'd5;         hzIf.EX_Rt = 5'd5;
        #1;
        checks++;
        if (hzIf.ForwardA !== 2'b10 || hzIf.ForwardB !== 2'b10) begin
            errors++;
            $display("[TB] FAIL fwd_mem_wins: got %b/%b expected 10/10", hzIf.ForwardA, hzIf.ForwardB);
        end
        hzIf.MEM_WriteReg = 5'd6;  hzIf.EX_Rt = 5'd6;
        #1;
        checks++;
        if (hzIf.ForwardA !== 2'b01 || hzIf.ForwardB !== 2'b10) begin
            errors++;
            $display("[TB] FAIL fwd_wb_only: got %b/%b expected 01/10", hzIf.ForwardA, hzIf.ForwardB);
        end
        hzIf.MEM_WriteReg = 5'd0;  hzIf.WB_WriteReg = 5'd0;
        hzIf.EX_Rs = 5'd0;         hzIf.EX_Rt = 5'd0;
        #1;
        checks++;
        if (hzIf.ForwardA !== 2'b00 || hzIf.ForwardB !== 2'b00) begin
            errors++;
            $display("[TB] FAIL fwd_reg0: got %b/%b expected 00/00", hzIf.ForwardA, hzIf.ForwardB);
        end
        hzIf.WB_WriteReg = 5'd9;  hzIf.EX_Rt = 5'd9;  hzIf.WB_RegWrite = 1'b0;
        #1;
        checks++;
        if (hzIf.ForwardB !== 2'b00) begin
            errors++;
            $display("[TB] FAIL fwd_no_write: got %b expected 00", hzIf.ForwardB);
        end
    endtask

    task automatic test_redirect();
        resetDut();
        driveLoadUse();
        hzIf.EX_BranchTaken = 1'b1;
        #1;
        checks++;
        if ({hzIf.PCSrc, hzIf.IFID_Flush, hzIf.IDEX_Flush, hzIf.PCWrite, hzIf.IFID_Write, hzIf.IDEX_Write} !== 7'b0111111) begin
            errors++;
            $display("[TB] FAIL branch_over_loaduse: got %b expected 0111111", {hzIf.PCSrc, hzIf.IFID_Flush, hzIf.IDEX_Flush, hzIf.PCWrite, hzIf.IFID_Write, hzIf.IDEX_Write});
        end
        @(negedge clk);
        hzIf.EX_Jump = 1'b1;
        #1;
        checks++;
        if (hzIf.PCSrc !== 2'b10 || hzIf.FlushCount !== CW'(1) || hzIf.StallCount !== '0) begin
            errors++;
            $display("[TB] FAIL jump_pcsrc: got src=%b flush=%0d stall=%0d expected 10/1/0", hzIf.PCSrc, hzIf.FlushCount, hzIf.StallCount);
        end
        @(negedge clk);
        setIdle();
        #1;
        checks++;
        if (hzIf.FlushCount !== CW'(2) || hzIf.PCSrc !== 2'b00) begin
            errors++;
            $display("[TB] FAIL redirect_count: got flush=%0d src=%b expected 2/00", hzIf.FlushCount, hzIf.PCSrc);
        end
    endtask

    task automatic test_multi();
        resetDut();
        hzIf.EX_MultiCycle = 1'b1;
        for (int t = 0; t < MC + 1; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 1) begin
                driveLoadUse();
                hzIf.EX_BranchTaken = 1'b1;
            end
            if (t == MC - 1) begin
                setIdle();
            end
            #1;
            checks++;
            if (t < MC - 1) begin
                if ({hzIf.PCWrite, hzIf.IFID_Write, hzIf.IDEX_Write, hzIf.EXMEM_Bubble, hzIf.MultiDone, hzIf.IFID_Flush, hzIf.PCSrc} !== 8'b00010000) begin
                    errors++;
                    $display("[TB] FAIL multi_stall t%0d: got %b expected 00010000", t, {hzIf.PCWrite, hzIf.IFID_Write, hzIf.IDEX_Write, hzIf.EXMEM_Bubble, hzIf.MultiDone, hzIf.IFID_Flush, hzIf.PCSrc});
                end
            end else if (t == MC - 1) begin
                if ({hzIf.PCWrite, hzIf.EXMEM_Bubble, hzIf.MultiDone} !== 3'b101) begin
                    errors++;
                    $display("[TB] FAIL multi_done: got %b expected 101", {hzIf.PCWrite, hzIf.EXMEM_Bubble, hzIf.MultiDone});
                end
            end else begin
                if (hzIf.MultiDone !== 1'b0 || hzIf.StallCount !== CW'(MC - 1)) begin
                    errors++;
                    $display("[TB] FAIL multi_after: got done=%b stall=%0d expected 0/%0d", hzIf.MultiDone, hzIf.StallCount, MC - 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_multi();
        resetDut();
        hzIf.EX_MultiCycle = 1'b1;
        @(negedge clk);
        hzIf.EX_MultiCycle = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (hzIf.PCWrite !== 1'b1 || hzIf.MultiDone !== 1'b0 || hzIf.StallCount !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_multi: got pcw=%b done=%b stall=%0d expected 1/0/0", hzIf.PCWrite, hzIf.MultiDone, hzIf.StallCount);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (hzIf.PCWrite !== 1'b1 || hzIf.MultiDone !== 1'b0 || hzIf.EXMEM_Bubble !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_run: got pcw=%b done=%b bub=%b expected 1/0/0", hzIf.PCWrite, hzIf.MultiDone, hzIf.EXMEM_Bubble);
        end
    endtask

    task automatic test_saturation();
        resetDut();
        driveLoadUse();
        repeat ((1 << CW) + 3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (hzIf.StallCount !== {CW{1'b1}}) begin
            errors++;
            $display("[TB] FAIL stall_saturate: got %0d expected %0d", hzIf.StallCount, (1 << CW) - 1);
        end
        setIdle();
    endtask

    task automatic test_random();
        int busy;
        int stallRef;
        int flushRef;
        logic lu, stallM, redir, luEff, done;
        logic [9:0] expCtl, gotCtl;
        logic [1:0] expSrc, expA, expB;
        busy = 0;
        stallRef = 0;
        flushRef = 0;
        resetDut();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            hzIf.ID_Rs = 5'($urandom_range(0, 3));      hzIf.ID_Rt = 5'($urandom_range(0, 3));
            hzIf.ID_UsesRs = 1'($urandom_range(0, 1));  hzIf.ID_UsesRt = 1'($urandom_range(0, 1));
            hzIf.EX_Rs = 5'($urandom_range(0, 3));      hzIf.EX_Rt = 5'($urandom_range(0, 3));
            hzIf.EX_MemRead = 1'($urandom_range(0, 1)); hzIf.EX_RegWrite = 1'($urandom_range(0, 1));
            hzIf.EX_WriteReg = 5'($urandom_range(0, 3));
            hzIf.EX_BranchTaken = ($urandom_range(0, 5) == 0);
            hzIf.EX_Jump = ($urandom_range(0, 7) == 0);
            hzIf.EX_MultiCycle = ($urandom_range(0, 7) == 0);
            hzIf.MEM_RegWrite = 1'($urandom_range(0, 1)); hzIf.MEM_WriteReg = 5'($urandom_range(0, 3));
            hzIf.WB_RegWrite = 1'($urandom_range(0, 1));  hzIf.WB_WriteReg = 5'($urandom_range(0, 3));
            #1;
            // busy = EX cycles still owed to the multi-cycle op in EX (0 = none).
            lu = hzIf.EX_MemRead && hzIf.EX_RegWrite && hzIf.EX_WriteReg != 0 &&
                 ((hzIf.ID_UsesRs && hzIf.ID_Rs == hzIf.EX_WriteReg) ||
                  (hzIf.ID_UsesRt && hzIf.ID_Rt == hzIf.EX_WriteReg));
            stallM = (busy > 1) || (busy == 0 && hzIf.EX_MultiCycle);
            done   = (busy == 1);
            redir  = (busy == 0) && !hzIf.EX_MultiCycle && (hzIf.EX_BranchTaken || hzIf.EX_Jump);
            luEff  = (busy == 0) && !hzIf.EX_MultiCycle && !redir && lu;
            expSrc = redir ? (hzIf.EX_Jump ? 2'b10 : 2'b01) : 2'b00;
            expCtl = {!(stallM || luEff), !(stallM || luEff), !stallM, redir, redir || luEff, stallM, done, expSrc, 1'b0};
            gotCtl = {hzIf.PCWrite, hzIf.IFID_Write, hzIf.IDEX_Write, hzIf.IFID_Flush, hzIf.IDEX_Flush,
                      hzIf.EXMEM_Bubble, hzIf.MultiDone, hzIf.PCSrc, 1'b0};
            expA = fwdRef(hzIf.EX_Rs, hzIf.MEM_RegWrite, hzIf.MEM_WriteReg, hzIf.WB_RegWrite, hzIf.WB_WriteReg);
            expB = fwdRef(hzIf.EX_Rt, hzIf.MEM_RegWrite, hzIf.MEM_WriteReg, hzIf.WB_RegWrite, hzIf.WB_WriteReg);
            checks++;
            if (gotCtl !== expCtl) begin
                errors++;
                $display("[TB] FAIL random_ctrl cycle %0d: got %b expected %b", i, gotCtl, expCtl);
            end
            checks++;
            if (hzIf.ForwardA !== expA || hzIf.ForwardB !== expB) begin
                errors++;
                $display("[TB] FAIL random_fwd cycle %0d: got %b/%b expected %b/%b", i, hzIf.ForwardA, hzIf.ForwardB, expA, expB);
            end
            checks++;
            if (hzIf.StallCount !== CW'(stallRef) || hzIf.FlushCount !== CW'(flushRef)) begin
                errors++;
                $display("[TB] FAIL random_counts cycle %0d: got %0d/%0d expected %0d/%0d", i, hzIf.StallCount, hzIf.FlushCount, stallRef, flushRef);
            end
            if ((stallM || luEff) && stallRef < (1 << CW) - 1) stallRef++;
            if (redir && flushRef < (1 << CW) - 1) flushRef++;
            if (busy > 0) busy--;
            else if (hzIf.EX_MultiCycle) busy = MC - 1;
        end
    endtask

    // Scenario sequence.
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        setIdle();
        test_reset();
        test_load_use();
        test_forwarding();
        test_redirect();
        test_multi();
        test_reset_mid_multi();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
